// File: rtl/ddr_rd_byte_stream.sv
// Reads a run of 256-bit words over the MIG 7-series app port and streams each
// word out LSB byte first on a valid/ready byte interface.
module ddr_rd_byte_stream #(
   parameter int unsigned ADDR_W         = 28,
   parameter int unsigned ADDR_STEP      = 8,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              init_calib_complete,
   input  logic              app_rdy,
   input  logic [255:0]      app_rd_data,
   input  logic              app_rd_data_valid,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned DATA_W   = 256;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned IDX_W    = 5;
   localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0]  CMD_READ = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WAIT,
      S_SHIFT,
      S_FIN
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    rem_q;
   logic [DATA_W-1:0]   word_q;
   logic [IDX_W-1:0]    idx_q;
   logic [TMO_W-1:0]    tmo_q;
   logic                app_en_q;
   logic                byte_valid_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;

   // Byte currently offered is always the low byte of the (shifting) word register.
   assign app_cmd    = CMD_READ;
   assign app_addr   = addr_q;
   assign app_en     = app_en_q;
   assign byte_data  = word_q[BYTE_W-1:0];
   assign byte_valid = byte_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         word_q       <= '0;
         idx_q        <= '0;
         tmo_q        <= '0;
         app_en_q     <= 1'b0;
         byte_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && init_calib_complete) begin
                  addr_q <= base_addr;
                  rem_q  <= word_count;
                  if (word_count == '0) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= S_CMD;
                     app_en_q <= 1'b1;
                     busy_q   <= 1'b1;
                  end
               end
            end

            S_CMD: begin
               if (app_rdy) begin
                  app_en_q <= 1'b0;
                  tmo_q    <= '0;
                  state_q  <= S_WAIT;
               end
            end

            // One read outstanding; give up after TIMEOUT_CYCLES idle cycles.
            S_WAIT: begin
               if (app_rd_data_valid) begin
                  word_q       <= app_rd_data;
                  idx_q        <= '0;
                  byte_valid_q <= 1'b1;
                  state_q      <= S_SHIFT;
               end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q <= S_FIN;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end

            S_SHIFT: begin
               if (byte_ready) begin
                  if (idx_q == IDX_W'(31)) begin
                     byte_valid_q <= 1'b0;
                     if (rem_q == CNT_W'(1)) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        rem_q    <= rem_q - CNT_W'(1);
                        addr_q   <= addr_q + ADDR_W'(ADDR_STEP);
                        app_en_q <= 1'b1;
                        state_q  <= S_CMD;
                     end
                  end else begin
                     idx_q  <= idx_q + IDX_W'(1);
                     word_q <= word_q >> BYTE_W;
                  end
               end
            end

            S_FIN: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_rd_byte_stream.sv
// Directed + randomized bench for ddr_rd_byte_stream; expected bytes, addresses
// and pulse timing come from a transaction-level model of the read run.
module tb_ddr_rd_byte_stream;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned STEP   = 8;
   localparam int unsigned TMO    = 16;

   logic              clock;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              init_calib_complete;
   logic              app_rdy;
   logic [255:0]      app_rd_data;
   logic              app_rd_data_valid;
   logic              app_en;
   logic [2:0]        app_cmd;
   logic [ADDR_W-1:0] app_addr;
   logic [7:0]        byte_data;
   logic              byte_valid;
   logic              byte_ready;
   logic              busy;
   logic              done;
   logic              err;

   int n_cmp = 0;
   int n_err = 0;

   ddr_rd_byte_stream #(
      .ADDR_W(ADDR_W), .ADDR_STEP(STEP), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .init_calib_complete(init_calib_complete),
      .app_rdy(app_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .app_en(app_en), .app_cmd(app_cmd),
      .app_addr(app_addr), .byte_data(byte_data), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .busy(busy), .done(done), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Pulse start for one cycle; scramble the run inputs afterwards so latching is exercised.
   task automatic start_run(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] wc);
      base_addr  = base;
      word_count = wc;
      start      = 1'b1;
      step();
      start      = 1'b0;
      base_addr  = ADDR_W'($urandom);
      word_count = CNT_W'($urandom);
   endtask

   // One word: command handshake, read return, 32-byte drain. rmode 0=ready high, 1=toggle, 2=random.
   task automatic do_word(input logic [ADDR_W-1:0] exp_addr, input logic [255:0] data,
                          input int rdy_delay, input int lat, input int rmode,
                          input bit last, input bit poke_start);
      int idx;
      int guard;
      logic r;
      logic [7:0] exp_b;
      chk1("app_en_up", app_en, 1'b1);
      chkv("app_addr", 32'(app_addr), 32'(exp_addr));
      chkv("app_cmd", 32'(app_cmd), 32'h1);
      chk1("busy_run", busy, 1'b1);
      for (int k = 0; k < rdy_delay; k++) begin
         app_rdy = 1'b0;
         step();
         chk1("app_en_hold", app_en, 1'b1);
         chkv("app_addr_hold", 32'(app_addr), 32'(exp_addr));
      end
      app_rdy = 1'b1;
      step();
      app_rdy = 1'b0;
      chk1("app_en_drop", app_en, 1'b0);
      for (int k = 0; k < lat; k++) begin
         if (poke_start) start = 1'($urandom_range(0, 1));
         step();
         chk1("wait_no_valid", byte_valid, 1'b0);
         chk1("wait_no_cmd", app_en, 1'b0);
      end
      start             = 1'b0;
      app_rd_data       = data;
      app_rd_data_valid = 1'b1;
      step();
      app_rd_data_valid = 1'b0;
      app_rd_data       = rand256();
      idx   = 0;
      guard = 0;
      while (idx < 32 && guard < 400) begin
         if (rmode == 0)      r = 1'b1;
         else if (rmode == 1) r = (guard % 2 == 0);
         else                 r = 1'($urandom_range(0, 1));
         byte_ready = r;
         exp_b = data[8*idx +: 8];
         chk1("byte_valid", byte_valid, 1'b1);
         chkv("byte_data", 32'(byte_data), 32'(exp_b));
         chk1("no_cmd_in_shift", app_en, 1'b0);
         step();
         if (r) idx++;
         guard++;
      end
      if (idx < 32) chkv("byte_drain_bound", 32'(idx), 32'd32);
      byte_ready = 1'($urandom_range(0, 1));
      chk1("byte_valid_end", byte_valid, 1'b0);
      if (last) begin
         chk1("done_pulse", done, 1'b1);
         chk1("err_clear", err, 1'b0);
         chk1("busy_fin", busy, 1'b0);
         chk1("no_cmd_fin", app_en, 1'b0);
         step();
         chk1("done_one_cycle", done, 1'b0);
         chk1("busy_idle", busy, 1'b0);
      end
   endtask

   initial begin
      logic [255:0]      d;
      logic [ADDR_W-1:0] base;
      int                wc;

      rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
      init_calib_complete = 1'b0; app_rdy = 1'b0; app_rd_data = '0;
      app_rd_data_valid = 1'b0; byte_ready = 1'b0;
      step();
      step();
      chk1("rst_app_en", app_en, 1'b0);
      chk1("rst_byte_valid", byte_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chkv("rst_addr", 32'(app_addr), 32'h0);
      chkv("rst_byte", 32'(byte_data), 32'h0);
      rst_n = 1'b1;
      step();

      // Start without calibration is ignored.
      start_run(28'h100, 16'd1);
      for (int k = 0; k < 3; k++) begin
         chk1("nocal_app_en", app_en, 1'b0);
         chk1("nocal_busy", busy, 1'b0);
         chk1("nocal_done", done, 1'b0);
         step();
      end
      init_calib_complete = 1'b1;

      // Zero-length run: immediate done, no command.
      start_run(28'h180, 16'd0);
      chk1("wc0_done", done, 1'b1);
      chk1("wc0_app_en", app_en, 1'b0);
      chk1("wc0_busy", busy, 1'b0);
      chk1("wc0_err", err, 1'b0);
      step();
      chk1("wc0_done_drop", done, 1'b0);
      chk1("wc0_app_en2", app_en, 1'b0);

      // Single word, bytes 0x00..0x1F, ready tied high.
      for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
      start_run(28'h100, 16'd1);
      do_word(28'h100, d, 0, 2, 0, 1'b1, 1'b0);

      // Two words with toggling ready.
      start_run(28'h200, 16'd2);
      do_word(28'h200, rand256(), 0, 1, 1, 1'b0, 1'b0);
      do_word(28'h208, rand256(), 0, 3, 1, 1'b1, 1'b0);

      // app_rdy low for 5 cycles.
      start_run(28'h340, 16'd1);
      do_word(28'h340, rand256(), 5, 0, 0, 1'b1, 1'b0);

      // Read timeout.
      start_run(28'h300, 16'd1);
      chk1("tmo_app_en", app_en, 1'b1);
      app_rdy = 1'b1;
      step();
      app_rdy = 1'b0;
      chk1("tmo_app_en_drop", app_en, 1'b0);
      for (int k = 1; k < int'(TMO); k++) begin
         step();
         chk1("tmo_done_early", done, 1'b0);
         chk1("tmo_byte_valid", byte_valid, 1'b0);
         chk1("tmo_busy", busy, 1'b1);
      end
      step();
      chk1("tmo_done", done, 1'b1);
      chk1("tmo_err", err, 1'b1);
      chk1("tmo_busy_drop", busy, 1'b0);
      chk1("tmo_byte_valid_end", byte_valid, 1'b0);
      step();
      chk1("tmo_done_drop", done, 1'b0);
      chk1("tmo_err_drop", err, 1'b0);

      // Address wrap-around.
      start_run(28'hFFFFFF8, 16'd2);
      do_word(28'hFFFFFF8, rand256(), 1, 1, 0, 1'b0, 1'b0);
      do_word(28'h0000000, rand256(), 0, 2, 2, 1'b1, 1'b0);

      // Randomized runs; start pokes during WAIT must be ignored.
      for (int r = 0; r < 6; r++) begin
         base = ADDR_W'($urandom) & 28'hFFFFFF8;
         wc   = $urandom_range(1, 3);
         start_run(base, CNT_W'(wc));
         for (int w = 0; w < wc; w++) begin
            do_word(ADDR_W'(base + ADDR_W'(w * STEP)), rand256(), $urandom_range(0, 4),
                    $urandom_range(0, 6), $urandom_range(0, 2), (w == wc - 1), 1'b1);
         end
      end

      // Reset in the middle of SHIFT, then a stray read return.
      start_run(28'h400, 16'd1);
      app_rdy = 1'b1;
      step();
      app_rdy = 1'b0;
      app_rd_data = rand256();
      app_rd_data_valid = 1'b1;
      step();
      app_rd_data_valid = 1'b0;
      byte_ready = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      step();
      chk1("mrst_app_en", app_en, 1'b0);
      chk1("mrst_byte_valid", byte_valid, 1'b0);
      chk1("mrst_busy", busy, 1'b0);
      chk1("mrst_done", done, 1'b0);
      chk1("mrst_err", err, 1'b0);
      chkv("mrst_addr", 32'(app_addr), 32'h0);
      chkv("mrst_byte", 32'(byte_data), 32'h0);
      rst_n = 1'b1;
      app_rd_data = rand256();
      app_rd_data_valid = 1'b1;
      step();
      app_rd_data_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk1("stray_byte_valid", byte_valid, 1'b0);
         chk1("stray_busy", busy, 1'b0);
         chk1("stray_done", done, 1'b0);
         step();
      end

      // Recovery run after reset.
      start_run(28'h500, 16'd1);
      do_word(28'h500, rand256(), 2, 1, 2, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
